demux_stream_1xn: RTL and testbench
===================================

// Module: demux_stream_1xn
// PURPOSE
//  Registered, parametrised 1-to-N stream demultiplexer with per-channel valid/ready handshake.
//  One input stream carries a data word plus a channel select; the word is routed to one output
//  channel, or broadcast to all channels. One-entry holding register; full throughput when the
//  addressed sinks are ready. Successor to the combinational 1x8 demux, for datapath fan-out.
// PARAMETERS
//  WIDTH   8  data word width in bits (>=1)
//  N_OUT   8  number of output channels (2..256; need not be a power of two)
//  SEL_W   derived localparam = clog2(N_OUT); never overridden
// PORTS
//  clk       in   1            rising-edge clock; the only clock
//  rst_n     in   1            synchronous active-low reset, sampled on clk rising edge
//  s_valid   in   1            input word valid
//  s_ready   out  1            block can accept the input word this cycle
//  s_data    in   WIDTH        input word
//  s_sel     in   SEL_W        target channel index
//  s_bcast   in   1            1 = deliver to all channels; s_sel ignored
//  m_valid   out  N_OUT        per-channel valid; bit k belongs to channel k
//  m_ready   in   N_OUT        per-channel ready
//  m_data    out  WIDTH        shared output word, common to all channels
//  sel_err   out  1            1-cycle pulse: a non-broadcast word with s_sel >= N_OUT was dropped
//  err_cnt   out  8            saturating count of dropped words
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): pend=0, m_data=0, sel_err=0, err_cnt=0. Any held word is
//    discarded. Outputs: m_valid=0, s_ready=0 while rst_n=0; s_ready=1 in the first cycle after.
//  - State: data_q[WIDTH] and pend[N_OUT]. m_valid = pend. m_data = data_q.
//  - Accept is s_valid & s_ready. Latency is 1 cycle: the accepted word is on m_data, with its
//    m_valid bit(s) set, on the next cycle.
//  - Channel k is delivered when pend[k] & m_ready[k]; that pend bit clears at the clk edge.
//    Bits clear independently; broadcast completes when every bit has cleared.
//  - s_ready = rst_n & ((pend & ~m_ready) == 0). The register is free, or empties this cycle.
//    This gives a combinational m_ready->s_ready path. Back-to-back words pass at 1 word/clk.
//  - On accept, where dec = one-hot(s_sel):
//      pend_next = s_bcast ? all-ones : (s_sel < N_OUT ? dec : 0)
//    data_q loads s_data only if pend_next != 0. Otherwise data_q holds.
//  - Invalid select (!s_bcast, s_sel >= N_OUT, accepted):
//      word dropped; sel_err=1 for one cycle; err_cnt += 1, saturating at 255.
//      If the cycle before the drop held a word, that word's delivery completes normally.
//  - While pend != 0, data_q and pend bits not yet delivered stay stable. This holds whatever
//    s_valid, s_data or s_sel do.
//  - m_ready is ignored on channels whose pend bit is 0. m_ready may rise or fall at any cycle.
//  - There is no valid-before-ready dependency. m_valid never depends combinationally on
//    m_ready.
//  - Simultaneous accept and final delivery in one cycle: pend is loaded with pend_next,
//    not cleared.
// STRUCTURE
//  - Shared header demux_defs.vh holds:
//      the clog2 constant function
//      the ERR_CNT_W=8 constant
//  - Sub-module onehot_dec #(N_OUT) (sel -> N_OUT-bit one-hot, all-zero when sel >= N_OUT).
//    It is the parametrised generalisation of the existing decoder logic.
//  - Everything else is one always block for state plus continuous assigns for
//    s_ready, m_valid and m_data.
// TESTING (WIDTH=8, N_OUT=8 unless noted; all checks on clk edges)
//  1 Single route:
//      all m_ready=1; send data 8'hA5, sel=3.
//      -> next cycle m_valid=8'b0000_1000, m_data=A5; following cycle m_valid=0.
//  2 Back-pressure:
//      m_ready[2]=0; send 8'h3C to sel=2, then a second word.
//      -> m_valid[2] held, m_data=3C stable, s_ready=0 until m_ready[2]=1.
//      -> Second word appears the next cycle.
//  3 Broadcast, staggered ready:
//      send 8'h7E with s_bcast=1; raise m_ready bits one per cycle, 0..7.
//      -> pend clears one bit per cycle; s_ready=1 only in the cycle bit 7 handshakes.
//  4 Streaming:
//      all ready; 16 consecutive words, sel cycling 0..7.
//      -> one word out per clk, in order, no bubbles.
//  5 Invalid select (N_OUT=5):
//      send sel=6.
//      -> no m_valid, sel_err pulses once, err_cnt=1.
//      -> After 300 such words err_cnt=255.
//  6 Reset mid-op:
//      hold word on sel=1 with m_ready=0; drive rst_n=0 for 1 clk.
//      -> m_valid=0, err_cnt=0, word lost, s_ready=1 after release.

Source files
------------

// File: rtl/demux_stream_1xn_pkg.sv
// ---------------------------------------------------------------------------
// demux_stream_1xn_pkg
//   Shared definitions for the 1-to-N stream demultiplexer:
//     clog2      constant function used to size the channel select
//     ERR_CNT_W  width of the saturating dropped-word counter
//     ERR_CNT_MAX saturation value of that counter
// ---------------------------------------------------------------------------
package demux_stream_1xn_pkg;

   localparam int ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Bits needed to index n items; never below 1 so a 2-channel demux still
   // gets a 1-bit select.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/demux_stream_1xn_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
//   Binary select to N_OUT-bit one-hot decoder. Select values that do not
//   name an existing channel (sel >= N_OUT) decode to all zeros, which the
//   demux uses to detect an invalid target.
// Ports
//   sel     in   SEL_W   binary channel index
//   onehot  out  N_OUT   bit k set when sel == k
// ---------------------------------------------------------------------------
module onehot_dec #(
   parameter int N_OUT = 8,
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0] sel,
   output logic [N_OUT-1:0] onehot
);

   // Each output bit compares against its own index; indices only run up to
   // N_OUT-1, so out-of-range selects match nothing.
   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_bit
      assign onehot[gi] = (sel == SEL_W'(gi));
   end

endmodule

// File: rtl/demux_stream_1xn.sv
// ---------------------------------------------------------------------------
// demux_stream_1xn
//   Registered 1-to-N stream demultiplexer. An accepted input word is held in
//   a one-entry register and presented on the shared m_data bus with the
//   valid bit of its target channel (or of every channel for a broadcast).
//   Each channel retires its valid bit independently on its own handshake.
//   A new word is accepted as soon as the register is empty or is being
//   fully drained in the same cycle, giving one word per clock when sinks
//   keep up.
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      synchronous active-low reset
//   s_valid  in   1      input word valid
//   s_ready  out  1      input word can be taken this cycle
//   s_data   in   WIDTH  input word
//   s_sel    in   SEL_W  target channel index
//   s_bcast  in   1      deliver to every channel, s_sel ignored
//   m_valid  out  N_OUT  per-channel valid
//   m_ready  in   N_OUT  per-channel ready
//   m_data   out  WIDTH  output word shared by all channels
//   sel_err  out  1      one-cycle pulse when a word with a bad select is dropped
//   err_cnt  out  8      saturating count of dropped words
// ---------------------------------------------------------------------------
module demux_stream_1xn
   import demux_stream_1xn_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N_OUT = 8,
   localparam int SEL_W = clog2(N_OUT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WIDTH-1:0]     s_data,
   input  logic [SEL_W-1:0]     s_sel,
   input  logic                 s_bcast,
   output logic [N_OUT-1:0]     m_valid,
   input  logic [N_OUT-1:0]     m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic                 sel_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [WIDTH-1:0]     data_reg;
   logic [N_OUT-1:0]     pend_reg;
   logic [N_OUT-1:0]     pend_next;
   logic [N_OUT-1:0]     dec;
   logic                 accept;
   logic                 sel_bad;
   logic                 sel_err_reg;
   logic [ERR_CNT_W-1:0] err_cnt_reg;

   onehot_dec #(
      .N_OUT (N_OUT),
      .SEL_W (SEL_W)
   ) u_dec (
      .sel    (s_sel),
      .onehot (dec)
   );

   // Ready when no pending channel is stalled: either nothing is held, or
   // every held bit is handshaking now. This is the one combinational
   // m_ready -> s_ready path and it is what allows back-to-back words.
   assign s_ready = rst_n & ~|(pend_reg & ~m_ready);
   assign accept  = s_valid & s_ready;

   // A decoder result of zero on a directed word means the select names no
   // channel; that word is dropped rather than stored.
   assign sel_bad   = ~s_bcast & ~|dec;
   assign pend_next = s_bcast ? {N_OUT{1'b1}} : dec;

   // Valid is masked while in reset so nothing is offered before the state
   // register has actually been cleared.
   assign m_valid = pend_reg & {N_OUT{rst_n}};
   assign m_data  = data_reg;
   assign sel_err = sel_err_reg;
   assign err_cnt = err_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_reg    <= '0;
         data_reg    <= '0;
         sel_err_reg <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         sel_err_reg <= 1'b0;
         if (accept) begin
            // Accepting implies every held bit is delivering this cycle, so
            // loading over pend_reg never loses an undelivered channel.
            pend_reg <= pend_next;
            if (|pend_next) begin
               data_reg <= s_data;
            end
            if (sel_bad) begin
               sel_err_reg <= 1'b1;
               if (err_cnt_reg != ERR_CNT_MAX) begin
                  err_cnt_reg <= err_cnt_reg + 1'b1;
               end
            end
         end else begin
            // Bits retire independently; data_reg holds until all are gone.
            pend_reg <= pend_reg & ~m_ready;
         end
      end
   end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// ---------------------------------------------------------------------------
// tb_demux_stream_1xn
//   Two instances: u0 with 8 channels, u1 with 5 channels (selects 5..7 are
//   invalid there). Each channel has a queue of words still owed to it; the
//   monitor derives expected valid/ready/data/error behaviour from those
//   queues and a drop counter every cycle.
// ---------------------------------------------------------------------------
module tb_demux_stream_1xn;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid_a [2];
   logic [7:0] s_data_a  [2];
   logic [2:0] s_sel_a   [2];
   logic       s_bcast_a [2];
   logic [7:0] m_ready_a [2];
   logic       s_ready_a [2];

   logic [7:0] m_valid0, m_data0, err_cnt0;
   logic [4:0] m_valid1;
   logic [7:0] m_data1, err_cnt1;
   logic       sel_err0, sel_err1;

   int total = 0;
   int bad = 0;

   // model state
   logic [7:0] exp_q [2][8][$];
   int         drops [2];
   bit         drop_prev [2];

   always #5 clk = ~clk;

   demux_stream_1xn #(.WIDTH(8), .N_OUT(8)) u0 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid_a[0]), .s_ready(s_ready_a[0]), .s_data(s_data_a[0]),
      .s_sel(s_sel_a[0]), .s_bcast(s_bcast_a[0]),
      .m_valid(m_valid0), .m_ready(m_ready_a[0]), .m_data(m_data0),
      .sel_err(sel_err0), .err_cnt(err_cnt0)
   );

   demux_stream_1xn #(.WIDTH(8), .N_OUT(5)) u1 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid_a[1]), .s_ready(s_ready_a[1]), .s_data(s_data_a[1]),
      .s_sel(s_sel_a[1]), .s_bcast(s_bcast_a[1]),
      .m_valid(m_valid1), .m_ready(m_ready_a[1][4:0]), .m_data(m_data1),
      .sel_err(sel_err1), .err_cnt(err_cnt1)
   );

   task automatic chk(input int u, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL u%0d %s actual=%0h required=%0h t=%0t", u, nm, act, exp, $time);
      end
   endtask

   // Per-cycle check of one instance followed by recording of the word the
   // source is handing over (if the model says it is accepted).
   task automatic mon(input int u, input int n, input logic [7:0] mv,
                      input logic [7:0] mr, input logic [7:0] md, input logic sr,
                      input logic sv, input logic [7:0] sd, input logic [2:0] ss,
                      input logic sb, input logic se, input logic [7:0] ec);
      logic [7:0] exp_mv;
      logic [7:0] exp_d;
      bit         exp_sr;
      bit         drop_now;
      if (!rst_n) begin
         chk(u, "rst_m_valid", 32'(mv), 32'd0);
         chk(u, "rst_s_ready", 32'(sr), 32'd0);
         for (int k = 0; k < 8; k++) exp_q[u][k].delete();
         drops[u] = 0;
         drop_prev[u] = 1'b0;
         return;
      end
      exp_mv = '0;
      exp_sr = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (exp_q[u][k].size() > 0) begin
            exp_mv[k] = 1'b1;
            if (!mr[k]) exp_sr = 1'b0;
         end
      end
      chk(u, "m_valid", 32'(mv), 32'(exp_mv));
      chk(u, "s_ready", 32'(sr), 32'(exp_sr));
      chk(u, "sel_err", 32'(se), 32'(drop_prev[u]));
      chk(u, "err_cnt", 32'(ec), (drops[u] > 255) ? 32'd255 : 32'(drops[u]));
      for (int k = 0; k < n; k++) begin
         if (exp_mv[k] && mr[k]) begin
            exp_d = exp_q[u][k].pop_front();
            chk(u, "m_data", 32'(md), 32'(exp_d));
         end
      end
      drop_now = 1'b0;
      if (sv && exp_sr) begin
         if (sb) begin
            for (int k = 0; k < n; k++) exp_q[u][k].push_back(sd);
         end else if (int'(ss) < n) begin
            exp_q[u][ss].push_back(sd);
         end else begin
            drops[u]++;
            drop_now = 1'b1;
         end
      end
      drop_prev[u] = drop_now;
   endtask

   always @(negedge clk) begin
      mon(0, 8, m_valid0, m_ready_a[0], m_data0, s_ready_a[0], s_valid_a[0],
          s_data_a[0], s_sel_a[0], s_bcast_a[0], sel_err0, err_cnt0);
      mon(1, 5, {3'b000, m_valid1}, m_ready_a[1], m_data1, s_ready_a[1],
          s_valid_a[1], s_data_a[1], s_sel_a[1], s_bcast_a[1], sel_err1, err_cnt1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // Offer one word and hold it until accepted (bounded wait).
   task automatic send(input int u, input logic [7:0] d, input logic [2:0] s,
                       input logic b);
      int guard;
      s_valid_a[u] = 1'b1;
      s_data_a[u]  = d;
      s_sel_a[u]   = s;
      s_bcast_a[u] = b;
      guard = 0;
      @(negedge clk);
      while (!s_ready_a[u] && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 200) begin
         bad++;
         total++;
         $display("FAIL u%0d send_timeout actual=stalled required=accept t=%0t", u, $time);
      end else begin
         $display("xfer u%0d data=%02h sel=%0d bcast=%0d t=%0t", u, d, s, b, $time);
      end
      step();
      s_valid_a[u] = 1'b0;
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         s_valid_a[u] = 1'b0;
         s_data_a[u]  = '0;
         s_sel_a[u]   = '0;
         s_bcast_a[u] = 1'b0;
         m_ready_a[u] = '0;
         drops[u]     = 0;
         drop_prev[u] = 1'b0;
      end
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk(0, "post_rst_s_ready", 32'(s_ready_a[0]), 32'd1);
      chk(0, "post_rst_m_data", 32'(m_data0), 32'd0);
      chk(1, "post_rst_err_cnt", 32'(err_cnt1), 32'd0);
      step();

      // single route
      m_ready_a[0] = 8'hFF;
      send(0, 8'hA5, 3'd3, 1'b0);
      idle(3);

      // back-pressure on channel 2, second word waits behind it
      m_ready_a[0] = 8'hFB;
      send(0, 8'h3C, 3'd2, 1'b0);
      s_valid_a[0] = 1'b1;
      s_data_a[0]  = 8'h5A;
      s_sel_a[0]   = 3'd6;
      idle(4);
      m_ready_a[0] = 8'hFF;
      step();
      s_valid_a[0] = 1'b0;
      idle(2);

      // broadcast with staggered ready
      m_ready_a[0] = 8'h00;
      send(0, 8'h7E, 3'd0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         m_ready_a[0][i] = 1'b1;
         step();
      end
      idle(2);

      // streaming
      m_ready_a[0] = 8'hFF;
      for (int i = 0; i < 16; i++) send(0, 8'($urandom), 3'(i % 8), 1'b0);
      idle(2);

      // random traffic on u0
      for (int i = 0; i < 1500; i++) begin
         s_valid_a[0] = ($urandom % 4) != 0;
         s_data_a[0]  = 8'($urandom);
         s_sel_a[0]   = 3'($urandom);
         s_bcast_a[0] = ($urandom % 8) == 0;
         m_ready_a[0] = 8'($urandom | $urandom);
         step();
      end
      s_valid_a[0] = 1'b0;
      m_ready_a[0] = 8'hFF;
      idle(2);

      // invalid select on the 5-channel instance
      m_ready_a[1] = 8'hFF;
      send(1, 8'h99, 3'd6, 1'b0);
      @(negedge clk);
      chk(1, "drop_sel_err", 32'(sel_err1), 32'd1);
      chk(1, "drop_err_cnt", 32'(err_cnt1), 32'd1);
      chk(1, "drop_m_valid", 32'(m_valid1), 32'd0);
      step();

      for (int i = 0; i < 400; i++) begin
         s_valid_a[1] = ($urandom % 3) != 0;
         s_data_a[1]  = 8'($urandom);
         s_sel_a[1]   = 3'($urandom);
         s_bcast_a[1] = ($urandom % 8) == 0;
         m_ready_a[1] = 8'($urandom | $urandom);
         step();
      end
      m_ready_a[1] = 8'hFF;
      s_valid_a[1] = 1'b0;
      idle(2);
      s_valid_a[1] = 1'b1;
      s_bcast_a[1] = 1'b0;
      s_sel_a[1]   = 3'd6;
      idle(300);
      s_valid_a[1] = 1'b0;
      @(negedge clk);
      chk(1, "sat_err_cnt", 32'(err_cnt1), 32'd255);
      step();

      // reset while a word is held
      m_ready_a[0] = 8'h00;
      send(0, 8'h42, 3'd1, 1'b0);
      idle(2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk(0, "mid_rst_m_valid", 32'(m_valid0), 32'd0);
      chk(0, "mid_rst_s_ready", 32'(s_ready_a[0]), 32'd1);
      chk(0, "mid_rst_err_cnt", 32'(err_cnt0), 32'd0);
      chk(1, "mid_rst_err_cnt", 32'(err_cnt1), 32'd0);
      step();
      m_ready_a[0] = 8'hFF;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
